if_prefetch: RTL and testbench



---
 rtl/cpu_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/if_prefetch.sv | 106 ++++++++++
 tb/tb_if_prefetch.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: IF/ID bundle layout and fetch-side types.
// Imported by the prefetch buffer and the ID stage.
package cpu_pkg;

   localparam int IFID_W         = 65;
   localparam int IFID_VALID_BIT = 64;
   localparam int IFID_PC_MSB    = 63;
   localparam int IFID_PC_LSB    = 32;
   localparam int IFID_INSTR_MSB = 31;

   localparam logic [31:0] PC_INC = 32'd4;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } ifid_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_ent_t;

   typedef enum logic {
      PF_RUN,
      PF_FLUSH
   } pf_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} pairs.
// Flush discards all entries in one cycle by snapping rd_ptr to wr_ptr.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  fetch_ent_t             wdata,
   input  logic                   pop,
   input  logic                   flush,
   output fetch_ent_t             head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_ent_t       mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !flush;
   assign do_pop  = pop && !flush && (count != '0);
   assign head    = mem_q[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count
                + {{(CW-1){1'b0}}, do_push}
                - {{(CW-1){1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch buffer feeding the IF/ID register.
// Issues sequential fetches under a credit limit and flushes on redirect.
module if_prefetch
   import cpu_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              CLK,
   input  logic              RST_N,
   output logic              imem_req,
   output logic [31:0]       imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   input  logic              branch,
   input  logic [31:0]       jaddr,
   input  logic              stall,
   output logic [IFID_W-1:0] ifid
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

   pf_state_e       state_q;
   pf_state_e       state_d;
   logic [31:0]     fetch_pc;
   logic            inflight;
   logic [31:0]     inflight_pc;
   logic            drop;

   logic [CW-1:0]   count;
   fetch_ent_t      head;
   fetch_ent_t      wdata;
   logic [CW:0]     used;
   logic            accept;
   logic            discard;
   logic            push;
   logic            valid;
   logic            pop;

   // Credits cover both buffered entries and the response in flight.
   assign used     = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign imem_req = RST_N && !branch && (used < DEPTH_C);
   assign imem_addr = fetch_pc;
   assign accept   = imem_req && imem_ready;

   assign discard  = drop && (state_q == PF_FLUSH);
   assign push     = inflight && !discard && !branch;
   assign wdata    = '{pc: inflight_pc, instr: imem_rdata};

   assign valid    = (count != '0) && !branch;
   assign pop      = valid && !stall;

   always_comb begin
      ifid = '0;
      ifid[IFID_VALID_BIT] = valid;
      if (count != '0) begin
         ifid[IFID_PC_MSB:IFID_PC_LSB] = head.pc;
         ifid[IFID_INSTR_MSB:0]        = head.instr;
      end
   end

   always_comb begin
      state_d = PF_RUN;
      unique case (1'b1)
         branch:  state_d = PF_FLUSH;
         default: state_d = PF_RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= PF_RUN;
      else        state_q <= state_d;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         drop        <= 1'b0;
      end else begin
         inflight <= accept;
         drop     <= branch && inflight;
         if (accept) inflight_pc <= fetch_pc;
         if (branch)
            fetch_pc <= {jaddr[31:2], 2'b00};
         else if (accept)
            fetch_pc <= fetch_pc + PC_INC;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .flush (branch),
      .head  (head),
      .count (count)
   );

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch.
// Accepted fetches are queued; ifid pops are compared in order.
module tb_if_prefetch;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        branch = 1'b0;
   logic [31:0] jaddr = '0;
   logic        stall = 1'b0;
   logic [64:0] ifid;

   if_prefetch #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .branch     (branch),
      .jaddr      (jaddr),
      .stall      (stall),
      .ifid       (ifid)
   );

   always #5 CLK = ~CLK;

   int          errs = 0;
   int          checks = 0;
   logic [63:0] sb_q[$];
   logic [31:0] exp_pc = RESET_PC;
   bit          model_inf = 1'b0;
   bit          resp_pend = 1'b0;
   logic [31:0] resp_addr = '0;
   bit          rel_now = 1'b0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(input string tag, input logic [64:0] got,
                      input logic [64:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input bit br, input logic [31:0] ja,
                       input bit st, input bit rdy);
      int          buffered;
      logic [63:0] e;
      bit          acc;
      @(negedge CLK);
      imem_rdata = resp_pend ? mem(resp_addr) : $urandom;
      branch     = br;
      jaddr      = ja;
      stall      = st;
      imem_ready = rdy;
      if (rel_now) begin
         RST_N   = 1'b1;
         rel_now = 1'b0;
      end
      #1;
      buffered = sb_q.size() - int'(model_inf);
      chk("req", imem_req, !br && (sb_q.size() < DEPTH));
      chk("valid", ifid[64], !br && (buffered > 0));
      if (buffered == 0) chk("empty_fields", ifid[63:0], '0);
      if (imem_req) chk("addr", imem_addr, exp_pc);
      if (ifid[64] && !st && !br) begin
         if (buffered <= 0) begin
            chk("spurious_valid", ifid[64], 1'b0);
         end else begin
            e = sb_q.pop_front();
            chk("ifid", ifid[63:0], e);
         end
      end
      acc = imem_req && imem_ready;
      if (acc) begin
         sb_q.push_back({exp_pc, mem(exp_pc)});
         exp_pc += 32'd4;
      end
      model_inf = acc;
      if (br) begin
         sb_q.delete();
         model_inf = 1'b0;
         exp_pc = {ja[31:2], 2'b00};
      end
      resp_pend = acc;
      resp_addr = imem_addr;
   endtask

   initial begin
      int n;
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_ifid", ifid, '0);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, RESET_PC);
      rel_now = 1'b1;

      repeat (12) tick(0, 0, 0, 1);
      repeat (10) tick(0, 0, 1, 1);
      repeat (8) tick(0, 0, 0, 1);
      for (int i = 0; i < 12; i++) tick(0, 0, 0, (i % 2) == 0);

      n = 0;
      while (!(sb_q.size() == DEPTH && model_inf) && n < 20) begin
         tick(0, 0, 1, 1);
         n++;
      end
      chk("fill_3_plus_inflight", 65'(n < 20), 65'd1);
      tick(1, 32'h100, 1, 1);
      repeat (6) tick(0, 0, 0, 1);

      tick(1, 32'h203, 0, 1);
      repeat (5) tick(0, 0, 0, 1);
      tick(1, 32'h40, 0, 1);
      tick(1, 32'h80, 0, 1);
      repeat (6) tick(0, 0, 0, 1);

      @(negedge CLK);
      imem_rdata = resp_pend ? mem(resp_addr) : $urandom;
      RST_N = 1'b0;
      #1;
      chk("midrst_ifid", ifid, '0);
      chk("midrst_req", imem_req, 1'b0);
      chk("midrst_addr", imem_addr, RESET_PC);
      sb_q.delete();
      model_inf = 1'b0;
      exp_pc = RESET_PC;
      rel_now = 1'b1;
      repeat (10) tick(0, 0, 0, 1);

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 15) == 0)
            tick(1, $urandom & 32'h0000_fffc, 0, 1);
         else
            tick(0, 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0);
      end

      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         tick(0, 0, 0, 0);
         n++;
      end
      chk("drain", 65'(sb_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
